bus_arbiter: RTL and testbench
==============================

BUS_ARBITER -- requirements
Module: bus_arbiter

Interface
REQ-001 Parameter NUM_DEVICES, default 8, number of bus requesters (bit index = bus ID; CPU = 7).
REQ-002 Parameter ID_WIDTH, default 3, width of owner ID; SHALL satisfy 2**ID_WIDTH >= NUM_DEVICES.
REQ-003 Parameter MAX_HOLD, default 256, maximum consecutive grant cycles before forced revoke; 0 disables timeout.
REQ-004 clk  input  1  system bus clock (clk25MHz domain); all state on rising edge.
REQ-005 reset_L  input  1  one clock; reset is asynchronous and active-low.
REQ-006 req  input  NUM_DEVICES  per-device bus request, level, held high for the whole transaction.
REQ-007 ack  output  NUM_DEVICES  registered one-hot (or zero) grant to the owning device.
REQ-008 owner  output  ID_WIDTH  ID of current grant holder, drives bus data/ctrl mux select.
REQ-009 owner_valid  output  1  high exactly when ack is nonzero.
REQ-010 timeout  output  1  one-cycle pulse when a grant is forcibly revoked.

Function
REQ-011 State machine SHALL have three states: IDLE, GRANT, TURN.
REQ-012 IDLE: on an edge with req nonzero, SHALL register ack = one-hot(winner), owner = winner, hold_cnt = 0, go GRANT; with req zero, SHALL stay IDLE, ack = 0.
REQ-013 Winner SHALL be chosen round-robin: first set req bit searching upward from (last_owner+1) mod NUM_DEVICES, wrapping past NUM_DEVICES-1 to 0.
REQ-014 last_owner SHALL update to winner on every grant; reset value NUM_DEVICES-1, so device 0 wins first among simultaneous requesters.
REQ-015 GRANT: while req[owner]=1 and timeout not reached, ack and owner SHALL hold unchanged and hold_cnt SHALL increment by 1 per cycle, saturating.
REQ-016 GRANT: on an edge with req[owner]=0, SHALL clear ack, go TURN; no timeout pulse.
REQ-017 GRANT: on an edge with req[owner]=1, MAX_HOLD != 0 and hold_cnt = MAX_HOLD-1, SHALL clear ack, pulse timeout for one cycle, go TURN.
REQ-018 Release and timeout on the same edge SHALL be treated as release (timeout stays 0).
REQ-019 Requests from non-owners during GRANT SHALL be ignored (no preemption, including CPU).
REQ-020 TURN SHALL last exactly one cycle with ack = 0, then go IDLE; this gives a minimum 2-cycle ack-low gap between grants for bus turnaround.
REQ-021 Grant latency: req rising sampled in IDLE -> ack high on the next edge (1 cycle).
REQ-022 A revoked device still requesting SHALL be re-eligible, but round-robin places it last.
REQ-023 owner SHALL retain its last value while owner_valid = 0.
REQ-024 hold_cnt width SHALL be clog2(MAX_HOLD)+1; req bits at or above NUM_DEVICES do not exist.

Reset
REQ-025 reset_L low SHALL asynchronously force state IDLE, ack = 0, owner = 0, owner_valid = 0, timeout = 0, hold_cnt = 0, last_owner = NUM_DEVICES-1.
REQ-026 Reset asserted mid-GRANT SHALL drop ack without passing through TURN; first arbitration after reset_L rises occurs on the first subsequent edge in IDLE.

Verification
REQ-027 Reset, then req = 8'b1000_0001 -> ack = 8'b0000_0001, owner = 0 one edge later.
REQ-028 Device 0 drops req, devices 0 and 7 then both request -> ack = 0 for 2 cycles, then ack = 8'b1000_0000, owner = 7.
REQ-029 req = 8'hFF held with each owner releasing after 3 cycles -> grant order 0,1,...,7,0 with 2-cycle gaps.
REQ-030 MAX_HOLD = 4, device 6 holds req -> ack[6] high 4 cycles, then timeout = 1 for one cycle, ack = 0 for 2 cycles, ack[6] regranted if alone.
REQ-031 MAX_HOLD = 4, device 6 drops req on the timeout cycle -> timeout stays 0, normal release.
REQ-032 reset_L pulsed low mid-GRANT (async, between edges) -> ack = 0 immediately; after release, req = 8'b0000_0100 -> ack = 8'b0000_0100 one edge later.

Source files
------------

// File: rtl/bus_arbiter_if.sv
// Shared bus arbitration signals: per-device requests in, one-hot grant and owner ID out.
// The master side is the arbiter; the slave side is the population of requesters.
interface bus_arbiter_if #(
    parameter int NUM_DEVICES = 8,
    parameter int ID_WIDTH    = 3
);
    logic [NUM_DEVICES-1:0] req;
    logic [NUM_DEVICES-1:0] ack;
    logic [ID_WIDTH-1:0]    owner;
    logic                   owner_valid;
    logic                   timeout;

    modport master (
        input  req,
        output ack,
        output owner,
        output owner_valid,
        output timeout
    );

    modport slave (
        output req,
        input  ack,
        input  owner,
        input  owner_valid,
        input  timeout
    );
endinterface

// File: rtl/bus_arbiter.sv
// Round-robin, non-preemptive bus arbiter with a hold-time limit and a one-cycle
// turnaround state, giving at least two ack-low cycles between consecutive grants.
module bus_arbiter #(
    parameter int NUM_DEVICES = 8,
    parameter int ID_WIDTH    = 3,
    parameter int MAX_HOLD    = 256
) (
    input  logic            clk,
    input  logic            reset_L,
    bus_arbiter_if.master   bus
);

    localparam int NUM_IDS = 2 ** ID_WIDTH;
    localparam int CNT_W   = $clog2(MAX_HOLD) + 1;
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);
    localparam logic [ID_WIDTH-1:0] LAST_DEV = ID_WIDTH'(NUM_DEVICES - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        TURN  = 2'd2
    } state_e;

    state_e                 state_q, state_d;
    logic [NUM_DEVICES-1:0] ack_q, ack_d;
    logic [ID_WIDTH-1:0]    owner_q, owner_d;
    logic [ID_WIDTH-1:0]    last_owner_q, last_owner_d;
    logic [CNT_W-1:0]       hold_cnt_q, hold_cnt_d;
    logic                   timeout_q, timeout_d;

    logic [NUM_IDS-1:0]     req_ext;
    logic [ID_WIDTH-1:0]    winner;

    // Padding to the full ID space lets req be indexed by owner without a range check.
    assign req_ext = NUM_IDS'(bus.req);

    function automatic logic [ID_WIDTH-1:0] rr_idx(input logic [ID_WIDTH-1:0] base,
                                                   input int step);
        return ID_WIDTH'((int'(base) + step) % NUM_DEVICES);
    endfunction

    // Scan from farthest to nearest so the nearest requester above last_owner wins.
    always_comb begin
        winner = last_owner_q;
        for (int i = NUM_DEVICES; i >= 1; i--) begin
            if (req_ext[rr_idx(last_owner_q, i)]) begin
                winner = rr_idx(last_owner_q, i);
            end
        end
    end

    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path can infer a latch.
        state_d      = state_q;
        ack_d        = ack_q;
        owner_d      = owner_q;
        last_owner_d = last_owner_q;
        hold_cnt_d   = hold_cnt_q;
        timeout_d    = 1'b0;

        case (state_q)
            IDLE: begin
                if (|bus.req) begin
                    ack_d        = NUM_DEVICES'(1) << winner;
                    owner_d      = winner;
                    last_owner_d = winner;
                    hold_cnt_d   = '0;
                    state_d      = GRANT;
                end else begin
                    ack_d = '0;
                end
            end

            GRANT: begin
                if (!req_ext[owner_q]) begin
                    ack_d   = '0;
                    state_d = TURN;
                end else if (MAX_HOLD != 0 && hold_cnt_q == HOLD_LAST) begin
                    ack_d     = '0;
                    timeout_d = 1'b1;
                    state_d   = TURN;
                end else if (hold_cnt_q != '1) begin
                    hold_cnt_d = hold_cnt_q + 1'b1;
                end
            end

            TURN: begin
                ack_d   = '0;
                state_d = IDLE;
            end

            default: begin
                ack_d   = '0;
                state_d = IDLE;
            end
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            state_q      <= IDLE;
            ack_q        <= '0;
            owner_q      <= '0;
            last_owner_q <= LAST_DEV;
            hold_cnt_q   <= '0;
            timeout_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            ack_q        <= ack_d;
            owner_q      <= owner_d;
            last_owner_q <= last_owner_d;
            hold_cnt_q   <= hold_cnt_d;
            timeout_q    <= timeout_d;
        end
    end

    assign bus.ack         = ack_q;
    assign bus.owner       = owner_q;
    assign bus.owner_valid = |ack_q;
    assign bus.timeout     = timeout_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed bench for bus_arbiter (MAX_HOLD = 4): grant latency, round-robin order,
// turnaround gaps, hold timeout, release-vs-timeout priority, no preemption, async reset.
module tb_bus_arbiter;

    localparam int N  = 8;
    localparam int IW = 3;
    localparam int MH = 4;

    logic clk;
    logic reset_L;

    int n_checks = 0;
    int n_errors = 0;

    bus_arbiter_if #(.NUM_DEVICES(N), .ID_WIDTH(IW)) bus ();

    bus_arbiter #(
        .NUM_DEVICES(N),
        .ID_WIDTH   (IW),
        .MAX_HOLD   (MH)
    ) dut (
        .clk    (clk),
        .reset_L(reset_L),
        .bus    (bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one rising edge and settle 1 ns past it before sampling.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_state(input string tag, input logic [N-1:0] exp_ack,
                                input logic [IW-1:0] exp_owner, input logic exp_to);
        check({tag, ".ack"},   32'(bus.ack), 32'(exp_ack));
        check({tag, ".owner"}, 32'(bus.owner), 32'(exp_owner));
        check({tag, ".valid"}, 32'(bus.owner_valid), 32'(|exp_ack));
        check({tag, ".tmo"},   32'(bus.timeout), 32'(exp_to));
    endtask

    initial begin
        logic [N-1:0] onehot;

        reset_L = 1'b0;
        bus.req = '0;
        repeat (3) tick();
        expect_state("reset", 8'h00, 3'd0, 1'b0);
        reset_L = 1'b1;
        tick();
        expect_state("idle_no_req", 8'h00, 3'd0, 1'b0);

        // CPU and device 0 together after reset: device 0 wins, one-edge latency.
        bus.req = 8'h81;
        tick();
        expect_state("first_grant", 8'h01, 3'd0, 1'b0);

        // Device 0 drops; 7 is still requesting but turnaround comes first.
        bus.req = 8'h80;
        tick();
        expect_state("drop0_turn", 8'h00, 3'd0, 1'b0);
        bus.req = 8'h81;
        tick();
        expect_state("drop0_idle", 8'h00, 3'd0, 1'b0);
        tick();
        expect_state("grant7", 8'h80, 3'd7, 1'b0);

        bus.req = 8'h00;
        tick();
        tick();
        tick();
        expect_state("idle_after7", 8'h00, 3'd7, 1'b0);

        // All devices request; each holds 3 cycles and releases, then re-requests.
        bus.req = 8'hFF;
        tick();
        for (int k = 0; k < 9; k++) begin
            onehot = 8'h01 << (k % N);
            expect_state($sformatf("rr%0d_grant", k), onehot, IW'(k % N), 1'b0);
            tick();
            tick();
            check($sformatf("rr%0d_hold", k), 32'(bus.ack), 32'(onehot));
            bus.req = 8'hFF & ~onehot;
            tick();
            check($sformatf("rr%0d_gap1", k), 32'(bus.ack), 32'h0);
            bus.req = 8'hFF;
            tick();
            check($sformatf("rr%0d_gap2", k), 32'(bus.ack), 32'h0);
            tick();
        end
        expect_state("rr_final", 8'h02, 3'd1, 1'b0);
        bus.req = 8'h00;
        tick();
        tick();

        // Device 6 alone holds past MAX_HOLD: 4 grant cycles, timeout pulse, 2-cycle gap.
        bus.req = 8'h40;
        tick();
        expect_state("to_c1", 8'h40, 3'd6, 1'b0);
        for (int c = 2; c <= 4; c++) begin
            tick();
            expect_state($sformatf("to_c%0d", c), 8'h40, 3'd6, 1'b0);
        end
        tick();
        expect_state("to_pulse", 8'h00, 3'd6, 1'b1);
        tick();
        expect_state("to_gap2", 8'h00, 3'd6, 1'b0);
        tick();
        expect_state("to_regrant", 8'h40, 3'd6, 1'b0);

        // Release on the would-be timeout edge counts as a normal release.
        tick();
        tick();
        tick();
        expect_state("rel_c4", 8'h40, 3'd6, 1'b0);
        bus.req = 8'h00;
        tick();
        expect_state("rel_no_to", 8'h00, 3'd6, 1'b0);
        tick();
        expect_state("rel_idle", 8'h00, 3'd6, 1'b0);

        // Device 2 granted; a CPU request during the grant must not preempt it.
        bus.req = 8'h04;
        tick();
        expect_state("grant2", 8'h04, 3'd2, 1'b0);
        bus.req = 8'h84;
        tick();
        expect_state("no_preempt", 8'h04, 3'd2, 1'b0);

        // Async reset between edges drops the grant at once.
        #1 reset_L = 1'b0;
        #1;
        expect_state("async_rst", 8'h00, 3'd0, 1'b0);
        #1 reset_L = 1'b1;
        bus.req = 8'h04;
        tick();
        expect_state("post_rst_grant", 8'h04, 3'd2, 1'b0);

        bus.req = 8'h00;
        tick();
        tick();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
